// File: rtl/seq_pkg.sv
// Shared types and defaults for the instruction sequencer.
// Holds the FSM state enum, the HALT word and default sizing.
package seq_pkg;

  localparam int DEF_NUM_PROGS = 6;
  localparam int DEF_PC_W      = 7;
  localparam int DEF_INST_W    = 16;
  localparam int DEF_ADDR_W    = 16;

  // All-ones word; sliced down to the instruction width at use.
  localparam logic [63:0] HALT_INST = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_onehot_dec.sv
// Program index to one-hot decoder with a range-valid flag.
// idx_i: index in; oh_o: one-hot out; valid_o: idx_i < N.
module prog_onehot_dec #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [IW-1:0] idx_i,
  output logic [N-1:0]  oh_o,
  output logic          valid_o
);

  always_comb begin
    oh_o = '0;
    for (int k = 0; k < N; k++) begin
      oh_o[k] = (idx_i == IW'(k));
    end
    // Out-of-range indices match no bit.
    valid_o = |oh_o;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetches a selected program from external ROMs and streams it out.
// In: clk, rst, start, prog_sel, stall, rom_data. Out: rom_en, pc,
// inst, inst_valid, ram_addr, busy, done, err.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_PROGS = DEF_NUM_PROGS,
  parameter int PC_W      = DEF_PC_W,
  parameter int INST_W    = DEF_INST_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  localparam int SEL_W    = sel_width(NUM_PROGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SEL_W-1:0]            prog_sel,
  input  logic                        stall,
  input  logic [NUM_PROGS*INST_W-1:0] rom_data,
  output logic [NUM_PROGS-1:0]        rom_en,
  output logic [PC_W-1:0]             pc,
  output logic [INST_W-1:0]           inst,
  output logic                        inst_valid,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_PROGS-1:0] oh_q, oh_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 pend_q, pend_d;
  logic                 err_q, err_d;

  logic [NUM_PROGS-1:0] dec_oh;
  logic                 dec_ok;
  logic [INST_W-1:0]    slice;
  logic                 halt;
  logic                 issue;

  // Decode the requested index at start time; the one-hot
  // is latched so rom_en never depends on prog_sel mid-run.
  prog_onehot_dec #(
    .N (NUM_PROGS),
    .IW(SEL_W)
  ) u_dec (
    .idx_i  (prog_sel),
    .oh_o   (dec_oh),
    .valid_o(dec_ok)
  );

  always_comb begin
    slice = '0;
    for (int k = 0; k < NUM_PROGS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        slice = rom_data[k*INST_W +: INST_W];
      end
    end
  end

  // pend_q marks the cycle a fetch's data is on rom_data.
  assign halt = pend_q &&
                (slice == HALT_INST[INST_W-1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    oh_d    = oh_q;
    addr_d  = addr_q + ADDR_W'(pend_q);
    pend_d  = 1'b0;
    err_d   = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (dec_ok) begin
            state_d = RUN;
            sel_d   = prog_sel;
            oh_d    = dec_oh;
            cnt_d   = '0;
            addr_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        issue = !stall;
        if (halt) begin
          // A fetch issued alongside HALT is dropped.
          state_d = DONE;
        end else if (issue) begin
          pend_d = 1'b1;
          cnt_d  = cnt_q + PC_W'(1);
          if (&cnt_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      oh_q    <= '0;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      oh_q    <= oh_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign rom_en     = issue ? oh_q : '0;
  assign pc         = cnt_q;
  assign inst       = pend_q ? slice : '0;
  assign inst_valid = pend_q;
  assign ram_addr   = addr_q;
  assign busy       = (state_q == RUN) ||
                      (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign err        = err_q;

endmodule
